// File: rtl/bolme_birimi_pkg.sv
// Shared definitions for the radix-2 restoring divider (bolme_birimi):
// RV32M operation codes, FSM state encodings, width constants and
// two's-complement helper functions.
package bolme_birimi_pkg;

    localparam int BOLME_VERI_W  = 32;
    localparam int BOLME_SAYAC_W = 5;

    typedef enum logic [1:0] {
        BOLME_DIV  = 2'b00,
        BOLME_DIVU = 2'b01,
        BOLME_REM  = 2'b10,
        BOLME_REMU = 2'b11
    } bolme_islem_e;

    typedef enum logic [1:0] {
        BOLME_BOSTA   = 2'b00,
        BOLME_HESAPLA = 2'b01,
        BOLME_DUZELT  = 2'b10,
        BOLME_BITTI   = 2'b11
    } bolme_durum_e;

    // Two's-complement negation of a data word.
    function automatic logic [BOLME_VERI_W-1:0] ikiye_tumle(input logic [BOLME_VERI_W-1:0] x);
        return ~x + 32'd1;
    endfunction

    // Magnitude of a signed data word (0x80000000 maps to itself, read as unsigned).
    function automatic logic [BOLME_VERI_W-1:0] mutlak(input logic [BOLME_VERI_W-1:0] x);
        return x[BOLME_VERI_W-1] ? ikiye_tumle(x) : x;
    endfunction

endpackage

// File: rtl/bolme_birimi_adimi.sv
// One restoring-division step: shift the next dividend bit into the
// partial remainder and subtract the divisor when it fits.
module bolme_adimi
    import bolme_birimi_pkg::*;
(
    input  logic [BOLME_VERI_W:0]   kalan_i,
    input  logic                    bolum_bit_i,
    input  logic [BOLME_VERI_W-1:0] bolen_i,
    output logic [BOLME_VERI_W:0]   kalan_o,
    output logic                    bolum_bit_o
);

    logic [BOLME_VERI_W+1:0] aday_s;

    // Trial subtraction; the remainder always stays below the divisor, so the
    // restored or reduced value fits the 33-bit partial remainder.
    always_comb begin
        aday_s = {kalan_i, bolum_bit_i};
        if (aday_s >= {2'b00, bolen_i}) begin
            kalan_o     = aday_s[BOLME_VERI_W:0] - {1'b0, bolen_i};
            bolum_bit_o = 1'b1;
        end else begin
            kalan_o     = aday_s[BOLME_VERI_W:0];
            bolum_bit_o = 1'b0;
        end
    end

endmodule

// File: rtl/bolme_birimi.sv
// Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// Optional build macro BOLME_HIZLI_OZEL_EN: divide-by-zero and signed
// overflow skip the iteration phase and finish two cycles after start.
module bolme_birimi
    import bolme_birimi_pkg::*;
#(
    parameter int VERI_W  = 32,
    parameter int SAYAC_W = 5
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              basla_i,
    input  logic              iptal_i,
    input  logic              durdur_i,
    input  logic [1:0]        kontrol_i,
    input  logic [VERI_W-1:0] deger1_i,
    input  logic [VERI_W-1:0] deger2_i,
    output logic              mesgul_o,
    output logic              gecerli_o,
    output logic [VERI_W-1:0] sonuc_o
);

    bolme_durum_e        durum_r;
    logic [1:0]          kontrol_r;
    logic [VERI_W-1:0]   bolum_r;
    logic [VERI_W-1:0]   bolen_r;
    logic [VERI_W-1:0]   ham_bolunen_r;
    logic [VERI_W:0]     kalan_r;
    logic [SAYAC_W-1:0]  sayac_r;
    logic                bolum_isaret_r;
    logic                kalan_isaret_r;
    logic                sifir_bolen_r;
    logic                tasma_r;
    logic                mesgul_r;
    logic                gecerli_r;
    logic [VERI_W-1:0]   sonuc_r;

    logic                isaretli_s;
    logic                sifir_s;
    logic                tasma_s;
    logic [VERI_W:0]     adim_kalan_s;
    logic                adim_bit_s;
    logic [VERI_W-1:0]   duz_bolum_s;
    logic [VERI_W-1:0]   duz_kalan_s;
    logic [VERI_W-1:0]   duz_sonuc_s;

    bolme_adimi u_adim (
        .kalan_i     (kalan_r),
        .bolum_bit_i (bolum_r[VERI_W-1]),
        .bolen_i     (bolen_r),
        .kalan_o     (adim_kalan_s),
        .bolum_bit_o (adim_bit_s)
    );

    // Classify the incoming operation: signedness and the two special cases.
    always_comb begin
        isaretli_s = ~kontrol_i[0];
        sifir_s    = (deger2_i == 32'd0);
        tasma_s    = isaretli_s && (deger1_i == 32'h8000_0000) && (deger2_i == 32'hFFFF_FFFF);
    end

    // Sign correction, special-case forcing and result selection for DUZELT.
    always_comb begin
        duz_bolum_s = bolum_isaret_r ? ikiye_tumle(bolum_r) : bolum_r;
        duz_kalan_s = kalan_isaret_r ? ikiye_tumle(kalan_r[VERI_W-1:0]) : kalan_r[VERI_W-1:0];
        if (sifir_bolen_r) begin
            duz_bolum_s = 32'hFFFF_FFFF;
            duz_kalan_s = ham_bolunen_r;
        end else if (tasma_r) begin
            duz_bolum_s = 32'h8000_0000;
            duz_kalan_s = 32'd0;
        end else begin
            duz_bolum_s = duz_bolum_s;
            duz_kalan_s = duz_kalan_s;
        end
        if (kontrol_r[1]) begin
            duz_sonuc_s = duz_kalan_s;
        end else begin
            duz_sonuc_s = duz_bolum_s;
        end
    end

    // Divider FSM: flush beats stall, stall freezes everything, else advance.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            durum_r        <= BOLME_BOSTA;
            kontrol_r      <= 2'b00;
            bolum_r        <= 32'd0;
            bolen_r        <= 32'd0;
            ham_bolunen_r  <= 32'd0;
            kalan_r        <= 33'd0;
            sayac_r        <= 5'd0;
            bolum_isaret_r <= 1'b0;
            kalan_isaret_r <= 1'b0;
            sifir_bolen_r  <= 1'b0;
            tasma_r        <= 1'b0;
            mesgul_r       <= 1'b0;
            gecerli_r      <= 1'b0;
            sonuc_r        <= 32'd0;
        end else if (iptal_i) begin
            durum_r   <= BOLME_BOSTA;
            mesgul_r  <= 1'b0;
            gecerli_r <= 1'b0;
        end else if (durdur_i) begin
            durum_r   <= durum_r;
        end else begin
            case (durum_r)
                BOLME_BOSTA: begin
                    gecerli_r <= 1'b0;
                    if (basla_i) begin
                        kontrol_r      <= kontrol_i;
                        ham_bolunen_r  <= deger1_i;
                        bolum_r        <= isaretli_s ? mutlak(deger1_i) : deger1_i;
                        bolen_r        <= isaretli_s ? mutlak(deger2_i) : deger2_i;
                        bolum_isaret_r <= isaretli_s & (deger1_i[VERI_W-1] ^ deger2_i[VERI_W-1]);
                        kalan_isaret_r <= isaretli_s & deger1_i[VERI_W-1];
                        sifir_bolen_r  <= sifir_s;
                        tasma_r        <= tasma_s;
                        kalan_r        <= 33'd0;
                        sayac_r        <= 5'd31;
                        mesgul_r       <= 1'b1;
`ifdef BOLME_HIZLI_OZEL_EN
                        durum_r        <= (sifir_s | tasma_s) ? BOLME_DUZELT : BOLME_HESAPLA;
`else
                        durum_r        <= BOLME_HESAPLA;
`endif
                    end else begin
                        mesgul_r <= 1'b0;
                    end
                end
                BOLME_HESAPLA: begin
                    kalan_r <= adim_kalan_s;
                    bolum_r <= {bolum_r[VERI_W-2:0], adim_bit_s};
                    if (sayac_r == 5'd0) begin
                        durum_r <= BOLME_DUZELT;
                    end else begin
                        sayac_r <= sayac_r - 5'd1;
                    end
                end
                BOLME_DUZELT: begin
                    sonuc_r   <= duz_sonuc_s;
                    gecerli_r <= 1'b1;
                    durum_r   <= BOLME_BITTI;
                end
                BOLME_BITTI: begin
                    gecerli_r <= 1'b0;
                    mesgul_r  <= 1'b0;
                    durum_r   <= BOLME_BOSTA;
                end
                default: begin
                    gecerli_r <= 1'b0;
                    mesgul_r  <= 1'b0;
                    durum_r   <= BOLME_BOSTA;
                end
            endcase
        end
    end

    assign mesgul_o  = mesgul_r;
    assign gecerli_o = gecerli_r;
    assign sonuc_o   = sonuc_r;

endmodule

// File: tb/tb_bolme_birimi.sv
// Scoreboard bench for bolme_birimi: a driver pushes the reference result and
// the cycle in which gecerli_o must rise; a monitor pops and compares.
module tb_bolme_birimi;
    import bolme_birimi_pkg::*;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        basla_i = 1'b0;
    logic        iptal_i = 1'b0;
    logic        durdur_i = 1'b0;
    logic [1:0]  kontrol_i = 2'b00;
    logic [31:0] deger1_i = 32'd0;
    logic [31:0] deger2_i = 32'd0;
    logic        mesgul_o;
    logic        gecerli_o;
    logic [31:0] sonuc_o;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int kimlik_sayac = 0;
    logic onceki_gecerli = 1'b0;

    typedef struct {
        logic [31:0] sonuc;
        int          hedef;
        int          kimlik;
    } beklenti_t;

    beklenti_t kuyruk[$];

    bolme_birimi dut (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .basla_i   (basla_i),
        .iptal_i   (iptal_i),
        .durdur_i  (durdur_i),
        .kontrol_i (kontrol_i),
        .deger1_i  (deger1_i),
        .deger2_i  (deger2_i),
        .mesgul_o  (mesgul_o),
        .gecerli_o (gecerli_o),
        .sonuc_o   (sonuc_o)
    );

    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) cyc <= cyc + 1;

    // Reference: RISC-V division semantics via 64-bit arithmetic.
    function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa;
        longint sb;
        logic [31:0] q;
        logic [31:0] r;
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF;
            r = a;
        end else if (op[0] == 1'b0) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            q = 32'(sa / sb);
            r = 32'(sa % sb);
        end else begin
            q = a / b;
            r = a % b;
        end
        return op[1] ? r : q;
    endfunction

    function automatic int gecikme(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        bit ozel;
        ozel = (b == 32'd0) || (op[0] == 1'b0 && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
`ifdef BOLME_HIZLI_OZEL_EN
        if (ozel) return 2;
`endif
        return ozel ? 34 : 34;
    endfunction

    task automatic kontrol_et(input string ad, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h t=%0t", ad, got, exp, $time);
        end
    endtask

    task automatic islem_baslat(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                input int ek, input bit beklenir, output int t);
        @(negedge clk_i);
        kontrol_i = op;
        deger1_i  = a;
        deger2_i  = b;
        basla_i   = 1'b1;
        t = cyc;
        if (beklenir) begin
            kuyruk.push_back('{model(op, a, b), t + gecikme(op, a, b) + ek, kimlik_sayac});
            kimlik_sayac++;
        end
        @(negedge clk_i);
        basla_i  = 1'b0;
        kontrol_i = 2'($urandom_range(0, 3));
        deger1_i = $urandom;
        deger2_i = $urandom;
    endtask

    task automatic bos_bekle();
        int n = 0;
        while ((mesgul_o || kuyruk.size() != 0) && n < 200) begin
            @(negedge clk_i);
            n++;
        end
        if (n >= 200) begin
            checks++;
            errors++;
            $display("FAIL zaman_asimi got=busy exp=idle kalan=%0d", kuyruk.size());
            kuyruk.delete();
        end
    endtask

    // Monitor: each rising gecerli_o pops one expectation.
    initial begin
        beklenti_t b;
        forever begin
            @(negedge clk_i);
            if (rst_ni && gecerli_o && !onceki_gecerli) begin
                if (kuyruk.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL beklenmeyen_gecerli got=%h exp=none", sonuc_o);
                end else begin
                    b = kuyruk.pop_front();
                    kontrol_et($sformatf("sonuc#%0d", b.kimlik), sonuc_o, b.sonuc);
                    kontrol_et($sformatf("gecikme#%0d", b.kimlik), 32'(cyc), 32'(b.hedef));
                end
            end
            onceki_gecerli = gecerli_o & rst_ni;
        end
    end

    logic [1:0]  d_op [10] = '{BOLME_DIV, BOLME_REM, BOLME_REM, BOLME_DIV, BOLME_DIVU,
                               BOLME_REMU, BOLME_DIV, BOLME_REM, BOLME_DIV, BOLME_REM};
    logic [31:0] d_a  [10] = '{32'd100, 32'd100, 32'hFFFF_FF9C, 32'hFFFF_FF9C, 32'hFFFF_FFFF,
                               32'hFFFF_FFFF, 32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000};
    logic [31:0] d_b  [10] = '{32'd7, 32'd7, 32'd7, 32'd7, 32'd2,
                               32'd2, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};

    initial begin
        int t;
        int n;
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;

        repeat (3) @(negedge clk_i);
        kontrol_et("reset_mesgul", {31'd0, mesgul_o}, 32'd0);
        kontrol_et("reset_gecerli", {31'd0, gecerli_o}, 32'd0);
        kontrol_et("reset_sonuc", sonuc_o, 32'd0);
        rst_ni = 1'b1;

        for (int i = 0; i < 10; i++) begin
            islem_baslat(d_op[i], d_a[i], d_b[i], 0, 1'b1, t);
            bos_bekle();
        end

        // Ten stalled cycles in the middle of the iteration phase.
        islem_baslat(BOLME_DIV, 32'd100, 32'd7, 10, 1'b1, t);
        repeat (4) @(negedge clk_i);
        durdur_i = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk_i);
            kontrol_et("durdur_mesgul", {31'd0, mesgul_o}, 32'd1);
        end
        durdur_i = 1'b0;
        bos_bekle();

        // Stall while the result is presented.
        islem_baslat(BOLME_DIVU, 32'd1000, 32'd3, 0, 1'b1, t);
        n = 0;
        while (!gecerli_o && n < 100) begin
            @(negedge clk_i);
            n++;
        end
        durdur_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_i);
            kontrol_et("bitti_gecerli", {31'd0, gecerli_o}, 32'd1);
            kontrol_et("bitti_sonuc", sonuc_o, 32'd333);
        end
        durdur_i = 1'b0;
        @(negedge clk_i);
        kontrol_et("bitti_birak", {31'd0, gecerli_o}, 32'd0);
        bos_bekle();

        // Asynchronous reset in the middle of an operation.
        islem_baslat(BOLME_DIV, 32'd1000, 32'd7, 0, 1'b0, t);
        repeat (9) @(negedge clk_i);
        #2 rst_ni = 1'b0;
        #1;
        kontrol_et("async_mesgul", {31'd0, mesgul_o}, 32'd0);
        kontrol_et("async_gecerli", {31'd0, gecerli_o}, 32'd0);
        kontrol_et("async_sonuc", sonuc_o, 32'd0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        islem_baslat(BOLME_DIVU, 32'd9, 32'd3, 0, 1'b1, t);
        bos_bekle();

        // Flush at T+20: no result pulse may follow.
        islem_baslat(BOLME_REM, 32'd12345, 32'd67, 0, 1'b0, t);
        repeat (19) @(negedge clk_i);
        iptal_i = 1'b1;
        @(negedge clk_i);
        iptal_i = 1'b0;
        kontrol_et("iptal_mesgul", {31'd0, mesgul_o}, 32'd0);
        kontrol_et("iptal_gecerli", {31'd0, gecerli_o}, 32'd0);
        repeat (40) @(negedge clk_i);

        // Start request while busy is ignored.
        islem_baslat(BOLME_DIV, 32'd1000, 32'd10, 0, 1'b1, t);
        repeat (5) @(negedge clk_i);
        kontrol_i = BOLME_REMU;
        deger1_i  = 32'd77;
        deger2_i  = 32'd5;
        basla_i   = 1'b1;
        @(negedge clk_i);
        basla_i = 1'b0;
        bos_bekle();
        repeat (40) @(negedge clk_i);

        // Randomized operations with biased corner operands.
        for (int i = 0; i < 40; i++) begin
            op = 2'($urandom_range(0, 3));
            case ($urandom_range(0, 3))
                0: a = 32'h8000_0000;
                1: a = 32'($urandom_range(0, 1000));
                default: a = $urandom;
            endcase
            case ($urandom_range(0, 5))
                0: b = 32'd0;
                1: b = 32'hFFFF_FFFF;
                2: b = 32'($urandom_range(1, 20));
                default: b = $urandom;
            endcase
            islem_baslat(op, a, b, 0, 1'b1, t);
            bos_bekle();
        end

        repeat (5) @(negedge clk_i);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
